// File: rtl/conversor_bcd_display.sv
// Sequential 8-bit binary to 3-digit BCD converter (double dabble, 8 shifts)
// driving four active-low 7-segment displays with blanking and overflow flag.
module conversor_bcd_display (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] valor,
    input  logic       ov,
    output logic       ocupado,
    output logic       pronto,
    output logic [3:0] centenas,
    output logic [3:0] dezenas,
    output logic [3:0] unidades,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [6:0] hex3
);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        CONVERTE = 2'd1,
        FIM      = 2'd2
    } estado_t;

    estado_t     estado;
    estado_t     prox_estado;
    logic [3:0]  cont;
    logic [19:0] trab;
    logic [19:0] trab_ajust;
    logic        ov_reg;

    function automatic logic [3:0] ajusta(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Add-3 correction on the three BCD nibbles; the binary part passes through.
    always_comb begin
        trab_ajust = {ajusta(trab[19:16]), ajusta(trab[15:12]),
                      ajusta(trab[11:8]), trab[7:0]};
    end

    always_comb begin
        prox_estado = estado;
        case (estado)
            OCIOSO:   if (start) prox_estado = CONVERTE;
            CONVERTE: if (cont == 4'd7) prox_estado = FIM;
            FIM:      prox_estado = OCIOSO;
            default:  prox_estado = OCIOSO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) estado <= OCIOSO;
        else     estado <= prox_estado;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cont     <= 4'd0;
            trab     <= 20'd0;
            ov_reg   <= 1'b0;
            pronto   <= 1'b0;
            centenas <= 4'd0;
            dezenas  <= 4'd0;
            unidades <= 4'd0;
            hex0     <= 7'b1000000;
            hex1     <= SEG_BLANK;
            hex2     <= SEG_BLANK;
            hex3     <= SEG_BLANK;
        end else begin
            pronto <= (estado == FIM);
            case (estado)
                OCIOSO: begin
                    if (start) begin
                        trab   <= {12'd0, valor};
                        ov_reg <= ov;
                        cont   <= 4'd0;
                    end
                end
                CONVERTE: begin
                    trab <= trab_ajust << 1;
                    cont <= cont + 4'd1;
                end
                FIM: begin
                    // Display decode uses the same nibbles loaded into the digit registers.
                    centenas <= trab[19:16];
                    dezenas  <= trab[15:12];
                    unidades <= trab[11:8];
                    hex0     <= seg7(trab[11:8]);
                    hex1     <= (trab[19:12] == 8'd0) ? SEG_BLANK : seg7(trab[15:12]);
                    hex2     <= (trab[19:16] == 4'd0) ? SEG_BLANK : seg7(trab[19:16]);
                    hex3     <= ov_reg ? SEG_E : SEG_BLANK;
                end
                default: ;
            endcase
        end
    end

    assign ocupado = (estado != OCIOSO);

endmodule

// File: tb/tb_conversor_bcd_display.sv
// Directed plus randomized bench for conversor_bcd_display using a decimal
// arithmetic reference model and a segment lookup table.
module tb_conversor_bcd_display;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] valor;
    logic       ov;
    logic       ocupado;
    logic       pronto;
    logic [3:0] centenas;
    logic [3:0] dezenas;
    logic [3:0] unidades;
    logic [6:0] hex0;
    logic [6:0] hex1;
    logic [6:0] hex2;
    logic [6:0] hex3;

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] LTR_E = 7'b0000110;
    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};

    logic [3:0] exp_c, exp_d, exp_u;
    logic [6:0] exp_h0, exp_h1, exp_h2, exp_h3;

    conversor_bcd_display dut (
        .clk(clk), .rst(rst), .start(start), .valor(valor), .ov(ov),
        .ocupado(ocupado), .pronto(pronto),
        .centenas(centenas), .dezenas(dezenas), .unidades(unidades),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: decimal digits by division, display rules applied directly.
    task automatic set_exp(input int v, input logic o);
        exp_c  = 4'(v / 100);
        exp_d  = 4'((v / 10) % 10);
        exp_u  = 4'(v % 10);
        exp_h0 = seg_tab[exp_u];
        exp_h1 = (v < 10) ? BLANK : seg_tab[exp_d];
        exp_h2 = (v < 100) ? BLANK : seg_tab[exp_c];
        exp_h3 = o ? LTR_E : BLANK;
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, "_cen"}, 32'(centenas), 32'(exp_c));
        chk({tag, "_dez"}, 32'(dezenas), 32'(exp_d));
        chk({tag, "_uni"}, 32'(unidades), 32'(exp_u));
        chk({tag, "_hex0"}, 32'(hex0), 32'(exp_h0));
        chk({tag, "_hex1"}, 32'(hex1), 32'(exp_h1));
        chk({tag, "_hex2"}, 32'(hex2), 32'(exp_h2));
        chk({tag, "_hex3"}, 32'(hex3), 32'(exp_h3));
    endtask

    // Called at a negedge; returns at the negedge where pronto is high.
    task automatic do_conv(input logic [7:0] v, input logic o,
                           input bit hold, input logic [7:0] mid);
        int e;
        start = 1'b1;
        valor = v;
        ov    = o;
        @(posedge clk);
        @(negedge clk);
        if (hold) begin
            valor = mid;
        end else begin
            start = 1'b0;
            valor = 8'($urandom);
            ov    = 1'($urandom);
        end
        e = 0;
        chk("pronto_fall", 32'(pronto), 32'd0);
        while (!pronto && e < 20) begin
            chk("ocupado_busy", 32'(ocupado), 32'd1);
            if (e == 4) chk_outputs("held");
            @(negedge clk);
            e++;
        end
        chk("latency", 32'(e), 32'd9);
        set_exp(int'(v), o);
        chk_outputs($sformatf("conv_%0d", v));
        chk("ocupado_done", 32'(ocupado), 32'd0);
        chk("pronto_high", 32'(pronto), 32'd1);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        valor = 8'd0;
        ov    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        set_exp(0, 1'b0);
        chk_outputs("reset");
        chk("reset_ocupado", 32'(ocupado), 32'd0);
        chk("reset_pronto", 32'(pronto), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_conv(8'hFF, 1'b0, 0, 8'h00);
        do_conv(8'h00, 1'b0, 0, 8'h00);
        do_conv(8'h09, 1'b0, 0, 8'h00);
        do_conv(8'h64, 1'b0, 0, 8'h00);
        do_conv(8'h0A, 1'b0, 0, 8'h00);
        do_conv(8'h2A, 1'b1, 0, 8'h00);
        do_conv(8'($urandom), 1'b0, 0, 8'h00);

        // start held high; valor changes mid-conversion, then the held start is taken.
        do_conv(8'h11, 1'b0, 1, 8'h99);
        do_conv(8'h99, 1'b0, 0, 8'h00);

        for (int i = 0; i < 256; i++) do_conv(8'(i), 1'($urandom), 0, 8'h00);
        for (int i = 0; i < 20; i++) do_conv(8'($urandom_range(0, 255)), 1'($urandom), 0, 8'h00);

        // Reset in the middle of a conversion.
        start = 1'b1;
        valor = 8'd200;
        ov    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_exp(0, 1'b0);
        chk_outputs("abort");
        chk("abort_ocupado", 32'(ocupado), 32'd0);
        chk("abort_pronto", 32'(pronto), 32'd0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("abort_no_pronto", 32'(pronto), 32'd0);
            chk("abort_idle", 32'(ocupado), 32'd0);
        end

        // Reset and start together: start is lost.
        rst   = 1'b1;
        start = 1'b1;
        valor = 8'd77;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        chk("rst_start_idle", 32'(ocupado), 32'd0);
        @(negedge clk);
        chk("rst_start_idle2", 32'(ocupado), 32'd0);
        chk_outputs("rst_start");

        // Normal operation resumes after reset.
        do_conv(8'd123, 1'b1, 0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
